// File: rtl/cmd_burst_dispatcher.sv
// cmd_burst_dispatcher
//   Pops packed command words from a single-clock FIFO that has a one-cycle
//   registered read latency. Each word is expanded into len+1 beats on a
//   valid/ready port, with the address stepping by ADDR_STEP per beat.
//   NOP words (opcode 0) are popped and dropped without producing a beat.
//
// Ports
//   i_clk            rising-edge clock
//   i_reset          synchronous reset, active low (0 = reset)
//   i_fifo_data_out  FIFO read data, valid the cycle after o_fifo_get
//   i_fifo_empty_bar 1 = FIFO holds at least one word
//   o_fifo_get       pop strobe to the FIFO
//   o_cmd_valid      beat presented to the core
//   i_cmd_ready      core accepts the beat when o_cmd_valid & i_cmd_ready
//   o_cmd_op         opcode of the current beat
//   o_cmd_addr       address of the current beat
//   o_cmd_last       current beat is the final beat of its command
//   o_busy           FSM is not in IDLE
//
// Build option
//   DISPATCH_PREFETCH_EN : pop the next word in the same cycle the last beat
//   is accepted, shrinking the inter-command gap from 2 cycles to 1.
//   o_fifo_get then depends combinationally on i_cmd_ready.

module cmd_burst_dispatcher #(
  parameter  int CMD_W     = 3,
  parameter  int LEN_W     = 2,
  parameter  int ADDR_W    = 25,
  parameter  int ADDR_STEP = 4,
  localparam int WORD_W    = CMD_W + LEN_W + ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [WORD_W-1:0] i_fifo_data_out,
  input  logic              i_fifo_empty_bar,
  output logic              o_fifo_get,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic [CMD_W-1:0]  o_cmd_op,
  output logic [ADDR_W-1:0] o_cmd_addr,
  output logic              o_cmd_last,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CMD_W-1:0]  r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_cnt;
  logic              w_get;
  logic              w_accept;

  logic [CMD_W-1:0]  w_word_op;
  logic [LEN_W-1:0]  w_word_len;
  logic [ADDR_W-1:0] w_word_addr;

  assign w_word_op   = i_fifo_data_out[WORD_W-1 -: CMD_W];
  assign w_word_len  = i_fifo_data_out[ADDR_W+LEN_W-1 : ADDR_W];
  assign w_word_addr = i_fifo_data_out[ADDR_W-1:0];

  assign o_cmd_valid = (r_state == ISSUE);
  assign o_cmd_last  = (r_state == ISSUE) && (r_cnt == '0);
  assign o_busy      = (r_state != IDLE);
  assign o_cmd_op    = r_op;
  assign o_cmd_addr  = r_addr;
  assign w_accept    = o_cmd_valid & i_cmd_ready;

  // The pop strobe is combinational; mask it while reset is asserted so the
  // FIFO is never popped during the reset cycles themselves.
  assign o_fifo_get  = w_get & i_reset;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == WAIT) begin
        // NOP words leave op/addr untouched so they keep their last values.
        if (w_word_op != '0) begin
          r_op   <= w_word_op;
          r_addr <= w_word_addr;
          r_cnt  <= w_word_len;
        end
      end else if (w_accept) begin
        r_addr <= r_addr + ADDR_W'(ADDR_STEP);
        r_cnt  <= r_cnt - LEN_W'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_get  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_fifo_empty_bar) begin
          w_get  = 1'b1;
          w_next = WAIT;
        end
      end
      WAIT: begin
        w_next = (w_word_op == '0) ? IDLE : ISSUE;
      end
      ISSUE: begin
        if (w_accept && (r_cnt == '0)) begin
`ifdef DISPATCH_PREFETCH_EN
          if (i_fifo_empty_bar) begin
            w_get  = 1'b1;
            w_next = WAIT;
          end else begin
            w_next = IDLE;
          end
`else
          w_next = IDLE;
`endif
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmd_burst_dispatcher.sv
module tb_cmd_burst_dispatcher;

  localparam int CMD_W  = 3;
  localparam int LEN_W  = 2;
  localparam int ADDR_W = 25;
  localparam int WORD_W = CMD_W + LEN_W + ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [WORD_W-1:0] fifo_data_out;
  logic              fifo_empty_bar;
  logic              fifo_get;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CMD_W-1:0]  cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_last;
  logic              busy;

  int total = 0;
  int bad   = 0;

  cmd_burst_dispatcher dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_fifo_data_out (fifo_data_out),
    .i_fifo_empty_bar(fifo_empty_bar),
    .o_fifo_get      (fifo_get),
    .o_cmd_valid     (cmd_valid),
    .i_cmd_ready     (cmd_ready),
    .o_cmd_op        (cmd_op),
    .o_cmd_addr      (cmd_addr),
    .o_cmd_last      (cmd_last),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read, data valid the cycle after the pop.
  logic [WORD_W-1:0] fq[$];
  int pops = 0;
  always @(posedge clk) begin
    if (fifo_get) begin
      fifo_data_out <= fq[0];
      fq.delete(0);
      pops++;
      fifo_empty_bar <= (fq.size() != 0);
    end
  end

  function automatic logic [WORD_W-1:0] mk(input logic [2:0] op, input logic [1:0] len,
                                           input logic [24:0] a);
    return {op, len, a};
  endfunction

  task automatic push(input logic [WORD_W-1:0] w);
    fq.push_back(w);
    fifo_empty_bar = 1'b1;
  endtask

  // Per-cycle sampled outputs and accepted-beat log
  logic s_valid, s_last, s_get, s_busy;
  logic [2:0]  s_op;
  logic [24:0] s_addr;
  logic [24:0] acc_addr[$];
  logic [2:0]  acc_op[$];
  logic        acc_last[$];
  int          acc_cyc[$];
  int          cyc_n = 0;

  task automatic clear_log();
    acc_addr.delete(); acc_op.delete(); acc_last.delete(); acc_cyc.delete();
  endtask

  // One clock: drive ready shortly after the edge, then sample outputs.
  task automatic cyc(input logic rdy);
    @(posedge clk);
    #1 cmd_ready = rdy;
    #1;
    cyc_n++;
    s_valid = cmd_valid; s_last = cmd_last; s_get = fifo_get; s_busy = busy;
    s_op = cmd_op; s_addr = cmd_addr;
    if (cmd_valid && rdy) begin
      acc_addr.push_back(cmd_addr); acc_op.push_back(cmd_op);
      acc_last.push_back(cmd_last); acc_cyc.push_back(cyc_n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    push(mk(3'd3, 2'd0, 25'h10));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      total++;
      if (s_get !== 1'b0 || s_valid !== 1'b0 || s_busy !== 1'b0) begin
        bad++;
        $display("FAIL reset cyc%0d: get=%b valid=%b busy=%b, required 0 0 0", i, s_get, s_valid, s_busy);
      end
    end
    fq.delete();
    fifo_empty_bar = 1'b0;
    cyc(1'b1);
    reset = 1'b1;
    cyc(1'b1);
  endtask

  task automatic test_burst();
    int t0, tv;
    logic [24:0] ea [4] = '{25'h100, 25'h104, 25'h108, 25'h10C};
    clear_log();
    push(mk(3'd3, 2'd3, 25'h100));
    #1;
    total++;
    if (fifo_get !== 1'b1) begin bad++; $display("FAIL burst get: got %b, required 1", fifo_get); end
    t0 = cyc_n; tv = -1;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1);
      if (s_valid && tv < 0) tv = cyc_n;
    end
    total++;
    if (tv - t0 !== 2) begin bad++; $display("FAIL burst latency: got %0d, required 2", tv - t0); end
    total++;
    if (acc_addr.size() !== 4) begin
      bad++; $display("FAIL burst count: got %0d, required 4", acc_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (acc_addr[i] !== ea[i] || acc_last[i] !== (i == 3) || acc_op[i] !== 3'd3) begin
          bad++;
          $display("FAIL burst beat%0d: addr=%h last=%b op=%0d, required %h %b 3",
                   i, acc_addr[i], acc_last[i], acc_op[i], ea[i], (i == 3));
        end
      end
    end
    total++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
      bad++; $display("FAIL burst idle: valid=%b busy=%b, required 0 0", s_valid, s_busy);
    end
  endtask

  task automatic test_stall();
    logic pv, pr;
    logic [24:0] pa;
    logic [2:0] po;
    logic [24:0] ea [4] = '{25'h100, 25'h104, 25'h108, 25'h10C};
    clear_log();
    pv = 1'b0; pr = 1'b0; pa = '0; po = '0;
    push(mk(3'd3, 2'd3, 25'h100));
    for (int i = 0; i < 30; i++) begin
      logic r;
      r = ((i % 4) == 0) || ((i % 4) == 3);
      cyc(r);
      if (pv && !pr) begin
        total++;
        if (s_valid !== 1'b1 || s_addr !== pa || s_op !== po) begin
          bad++;
          $display("FAIL stall hold: valid=%b addr=%h op=%0d, required 1 %h %0d", s_valid, s_addr, s_op, pa, po);
        end
      end
      pv = s_valid; pr = r; pa = s_addr; po = s_op;
    end
    total++;
    if (acc_addr.size() !== 4) begin
      bad++; $display("FAIL stall accepts: got %0d, required 4", acc_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (acc_addr[i] !== ea[i] || acc_last[i] !== (i == 3)) begin
          bad++; $display("FAIL stall beat%0d: addr=%h last=%b, required %h %b", i, acc_addr[i], acc_last[i], ea[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_nop();
    int p0;
    clear_log();
    p0 = pops;
    push(mk(3'd0, 2'd2, 25'h55));
    push(mk(3'd1, 2'd0, 25'h20));
    for (int i = 0; i < 12; i++) cyc(1'b1);
    total++;
    if (pops - p0 !== 2) begin bad++; $display("FAIL nop pops: got %0d, required 2", pops - p0); end
    total++;
    if (acc_addr.size() !== 1) begin
      bad++; $display("FAIL nop beats: got %0d, required 1", acc_addr.size());
    end else begin
      total++;
      if (acc_addr[0] !== 25'h20 || acc_op[0] !== 3'd1 || acc_last[0] !== 1'b1) begin
        bad++; $display("FAIL nop beat: addr=%h op=%0d last=%b, required 20 1 1", acc_addr[0], acc_op[0], acc_last[0]);
      end
    end
  endtask

  task automatic test_wrap();
    clear_log();
    push(mk(3'd2, 2'd1, 25'h1FFFFFC));
    for (int i = 0; i < 10; i++) cyc(1'b1);
    total++;
    if (acc_addr.size() !== 2) begin
      bad++; $display("FAIL wrap beats: got %0d, required 2", acc_addr.size());
    end else begin
      total++;
      if (acc_addr[0] !== 25'h1FFFFFC || acc_addr[1] !== 25'h0 || acc_last[0] !== 1'b0 || acc_last[1] !== 1'b1) begin
        bad++; $display("FAIL wrap addr: got %h/%h last %b%b, required 1fffffc/0000000 01",
                        acc_addr[0], acc_addr[1], acc_last[0], acc_last[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    clear_log();
    hit = 0;
    push(mk(3'd3, 2'd3, 25'h200));
    for (int i = 0; i < 10 && !hit; i++) begin
      cyc(1'b1);
      if (acc_addr.size() == 1) hit = 1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL rstmid first beat: no accept within 10 cycles"); end
    reset = 1'b0;
    cyc(1'b1);
    total++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
      bad++; $display("FAIL rstmid valid: valid=%b busy=%b, required 0 0", s_valid, s_busy);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b1);
    total++;
    if (acc_addr.size() !== 1) begin
      bad++; $display("FAIL rstmid beats: got %0d, required 1", acc_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    int exp_gap;
`ifdef DISPATCH_PREFETCH_EN
    exp_gap = 1;
`else
    exp_gap = 2;
`endif
    clear_log();
    push(mk(3'd3, 2'd0, 25'h40));
    push(mk(3'd1, 2'd0, 25'h80));
    for (int i = 0; i < 14; i++) cyc(1'b1);
    total++;
    if (acc_addr.size() !== 2) begin
      bad++; $display("FAIL b2b beats: got %0d, required 2", acc_addr.size());
    end else begin
      total++;
      if (acc_addr[0] !== 25'h40 || acc_addr[1] !== 25'h80 || acc_op[1] !== 3'd1) begin
        bad++; $display("FAIL b2b addr: got %h/%h op%0d, required 40/80 op1", acc_addr[0], acc_addr[1], acc_op[1]);
      end
      total++;
      if (acc_cyc[1] - acc_cyc[0] - 1 !== exp_gap) begin
        bad++; $display("FAIL b2b gap: got %0d, required %0d", acc_cyc[1] - acc_cyc[0] - 1, exp_gap);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    cmd_ready = 1'b0;
    fifo_empty_bar = 1'b0;
    fifo_data_out = '0;
    test_reset();
    test_burst();
    test_stall();
    test_nop();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
